// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: byte FIFO feeding an 8-data, parity, 1-stop serial framer
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_D,
  output logic       Tx_BUSY,
  output logic       Tx_FULL,
  output logic       Tx_EMPTY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic ODD = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [14:0]   div_sel;
  logic [14:0]   div_q;
  logic [14:0]   tick_cnt;
  logic [3:0]    tick_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity;
  logic          tick_wrap;
  logic          bit_done;

  always_comb begin
    div_sel = 15'd54;
    case (baud_select)
      3'b000:  div_sel = 15'd20833;
      3'b001:  div_sel = 15'd5208;
      3'b010:  div_sel = 15'd1302;
      3'b011:  div_sel = 15'd651;
      3'b100:  div_sel = 15'd326;
      3'b101:  div_sel = 15'd163;
      3'b110:  div_sel = 15'd109;
      default: div_sel = 15'd54;
    endcase
  end

  assign tick_wrap = (tick_cnt == div_q - 15'd1);
  assign bit_done  = tick_wrap && (tick_idx == 4'd15);

  // A write while full is dropped even when a pop frees a slot in the same cycle.
  assign push = Tx_WR && !Tx_FULL;
  assign pop  = Tx_EN && !Tx_EMPTY &&
                ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Tx_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Tx_FULL  <= 1'b0;
      Tx_EMPTY <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      Tx_FULL  <= (count_next == CW'(FIFO_DEPTH));
      Tx_EMPTY <= (count_next == '0);
    end
  end

  // Launch clears both timing counters so the start bit gets a full 16 ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      Tx_D     <= 1'b1;
      Tx_BUSY  <= 1'b0;
      div_q    <= 15'd54;
      tick_cnt <= '0;
      tick_idx <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
    end else if (pop) begin
      state    <= ST_START;
      Tx_D     <= 1'b0;
      Tx_BUSY  <= 1'b1;
      div_q    <= div_sel;
      tick_cnt <= '0;
      tick_idx <= '0;
      bit_idx  <= '0;
      shift    <= mem[rd_ptr];
      parity   <= (^mem[rd_ptr]) ^ ODD;
    end else if (state != ST_IDLE) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        tick_idx <= tick_idx + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 15'd1;
      end
      if (bit_done) begin
        case (state)
          ST_START: begin
            state <= ST_DATA;
            Tx_D  <= shift[0];
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
              Tx_D  <= parity;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              Tx_D    <= shift[1];
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            Tx_D  <= 1'b1;
          end
          default: begin
            state   <= ST_IDLE;
            Tx_D    <= 1'b1;
            Tx_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized bench for uart_transmitter with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       Tx_D;
  logic       Tx_BUSY;
  logic       Tx_FULL;
  logic       Tx_EMPTY;

  always #5 clk = ~clk;

  uart_transmitter #(.FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
    .clk(clk),
    .reset(reset),
    .baud_select(baud_select),
    .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR),
    .Tx_DATA(Tx_DATA),
    .Tx_D(Tx_D),
    .Tx_BUSY(Tx_BUSY),
    .Tx_FULL(Tx_FULL),
    .Tx_EMPTY(Tx_EMPTY)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [2:0] s);
    case (s)
      3'b000:  return 20833;
      3'b001:  return 5208;
      3'b010:  return 1302;
      3'b011:  return 651;
      3'b100:  return 326;
      3'b101:  return 163;
      3'b110:  return 109;
      default: return 54;
    endcase
  endfunction

  // Model: a queue of bytes and the frame currently on the line, indexed by elapsed cycles.
  logic [7:0]  mq[$];
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_txd = 1'b1;
  logic [10:0] m_frame = '1;
  int          m_elapsed = 0;
  int          m_div = 54;

  always @(posedge clk) begin : model
    int sz;
    int e;
    int d;
    logic busy;
    logic launch;
    logic [10:0] fr;
    logic [7:0] b;
    sz = mq.size();
    e = m_elapsed;
    d = m_div;
    busy = m_busy;
    fr = m_frame;
    launch = 1'b0;
    if (reset) begin
      mq.delete();
      busy = 1'b0;
      e = 0;
    end else begin
      if (busy) begin
        e++;
        if (e == 176 * d) begin
          if (Tx_EN && sz > 0) launch = 1'b1;
          else busy = 1'b0;
        end
      end else if (Tx_EN && sz > 0) begin
        launch = 1'b1;
      end
      if (launch) begin
        b = mq.pop_front();
        fr = {1'b1, ^b, b, 1'b0};
        d = div_of(baud_select);
        e = 0;
        busy = 1'b1;
      end
      if (Tx_WR && sz < DEPTH) mq.push_back(Tx_DATA);
    end
    m_valid   <= 1'b1;
    m_busy    <= busy;
    m_elapsed <= e;
    m_div     <= d;
    m_frame   <= fr;
    m_txd     <= busy ? fr[4'(e / (16 * d))] : 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle", {Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY},
            {m_txd, m_busy, (mq.size() == DEPTH), (mq.size() == 0)});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    Tx_WR = 1'b1;
    Tx_DATA = d;
    tick();
    Tx_WR = 1'b0;
  endtask

  // Line decoder at 864 cycles per bit, sampling mid-bit on falling clock edges.
  task automatic rx_frame(output logic [7:0] b, output logic pe, output logic fe, output logic got);
    int n;
    logic par;
    b = '0;
    pe = 1'b0;
    fe = 1'b0;
    got = 1'b0;
    n = 0;
    while (Tx_D !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (Tx_D === 1'b0) begin
      repeat (432) @(negedge clk);
      if (Tx_D !== 1'b0) fe = 1'b1;
      for (int i = 0; i < 8; i++) begin
        repeat (864) @(negedge clk);
        b[i] = Tx_D;
      end
      repeat (864) @(negedge clk);
      par = Tx_D;
      repeat (864) @(negedge clk);
      if (Tx_D !== 1'b1) fe = 1'b1;
      pe = (par !== ^b);
      got = 1'b1;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic [10:0] seq;
    logic [7:0] rb;
    logic pe;
    logic fe;
    logic got;

    reset = 1'b1;
    baud_select = 3'b111;
    Tx_EN = 1'b0;
    Tx_WR = 1'b0;
    Tx_DATA = '0;
    tick(4);
    check("reset_vals", {Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY}, 4'b1001);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: line should read 0,10100101 (LSB first),0,1 -> 11'h54A
    Tx_EN = 1'b1;
    wr(8'hA5);
    check("t1_not_yet", {Tx_D, Tx_EMPTY}, 2'b10);
    tick();
    check("t1_fall", {Tx_D, Tx_BUSY}, 2'b01);
    cnt = 0;
    seq = '0;
    while (Tx_BUSY === 1'b1 && cnt < 20000) begin
      if (cnt < 9504 && cnt % 864 == 432) seq[4'(cnt / 864)] = Tx_D;
      cnt++;
      tick();
    end
    check("t1_busy_len", cnt, 9504);
    check("t1_bits", seq, 11'h54A);
    check("t1_idle", {Tx_D, Tx_EMPTY}, 2'b11);

    // FIFO fill with transmit disabled; the fifth and later writes are dropped
    Tx_EN = 1'b0;
    tick();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    check("t2_not_full", Tx_FULL, 1'b0);
    wr(8'h04);
    check("t2_full", Tx_FULL, 1'b1);
    wr(8'h05);
    repeat (3) wr(8'($urandom));
    check("t2_still_full", {Tx_FULL, Tx_BUSY}, 2'b10);
    Tx_EN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rx_frame(rb, pe, fe, got);
      check("t2_got", got, 1'b1);
      check("t2_byte", rb, 32'(i));
      check("t2_err", {pe, fe}, 2'b00);
    end
    n = 0;
    while (Tx_D !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t2_gap", n, 432);
    check("t2_empty_after_pop4", {Tx_EMPTY, Tx_BUSY}, 2'b11);

    // Reset during data bit 3 of the 0x04 frame with two more bytes queued
    @(posedge clk);
    #1;
    wr(8'h11);
    wr(8'h22);
    tick(3900);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_reset_abort", {Tx_D, Tx_BUSY, Tx_EMPTY}, 3'b101);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (Tx_D !== 1'b1) n++;
      tick();
    end
    check("t4_no_frames", n, 0);

    // Write on the launch cycle, then a baud change mid-frame
    Tx_EN = 1'b0;
    tick();
    wr(8'hFF);
    Tx_EN = 1'b1;
    Tx_WR = 1'b1;
    Tx_DATA = 8'h01;
    tick();
    Tx_WR = 1'b0;
    check("t3_wr_pop", {Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY}, 4'b0100);
    cnt = 0;
    seq = '0;
    while (cnt < 9504) begin
      if (cnt == 2000) baud_select = 3'b110;
      if (cnt % 864 == 432) seq[4'(cnt / 864)] = Tx_D;
      cnt++;
      tick();
    end
    check("t3_bits_ff", seq, 11'h5FE);
    check("t3_next_start", {Tx_D, Tx_BUSY, Tx_EMPTY}, 3'b011);
    n = 0;
    while (Tx_D === 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check("t3_start_len", n, 1744);
    n = 0;
    while (Tx_D === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("t3_bit0_len", n, 1744);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    baud_select = 3'b111;
    tick();

    // Loopback decode of 0x55 and 0xFB
    wr(8'h55);
    wr(8'hFB);
    rx_frame(rb, pe, fe, got);
    check("lb_got0", got, 1'b1);
    check("lb_byte0", rb, 8'h55);
    check("lb_err0", {pe, fe}, 2'b00);
    rx_frame(rb, pe, fe, got);
    check("lb_got1", got, 1'b1);
    check("lb_byte1", rb, 8'hFB);
    check("lb_err1", {pe, fe}, 2'b00);
    n = 0;
    while (Tx_BUSY === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("lb_done", {Tx_BUSY, Tx_EMPTY}, 2'b01);
    @(posedge clk);
    #1;

    // Random traffic, checked by the per-cycle model
    for (int c = 0; c < 4000; c++) begin
      Tx_WR = ($urandom_range(3) == 0);
      Tx_DATA = 8'($urandom);
      if ($urandom_range(63) == 0) Tx_EN = ~Tx_EN;
      if ($urandom_range(127) == 0) baud_select = 3'($urandom);
      reset = ($urandom_range(1999) == 0);
      tick();
    end
    Tx_WR = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_reset", {Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY}, 4'b1001);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
